imem_pipe: RTL and testbench
============================

Name: imem_pipe

Overview:
Parametrised, byte-addressed, big-endian instruction memory with a valid/ready fetch interface, configurable read latency and a word-wide program-load port. It serves the fetch stage of the MIPS datapath: the PC drives fetch requests, and the decode stage consumes the responses. Compared with the single-cycle fetch memory, it adds backpressure, pipelined latency, alignment checking and a runtime loader in place of initial-block programming.

Parameters:
ADDR_W, 32, width of fetch and load byte addresses
DEPTH_BYTES, 256, memory size in bytes; power of two, multiple of 4
LAT, 1, fetch latency in cycles from accepted request to rsp_valid; legal range 1..4

Ports:
clk  input  1  system clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
req_valid  input  1  fetch request valid
req_ready  output  1  fetch request accepted when req_valid && req_ready
req_addr  input  ADDR_W  fetch byte address (PC)
rsp_valid  output  1  response valid
rsp_ready  input  1  consumer accepts response
rsp_instr  output  32  fetched word; byte at addr goes to [31:24], addr+3 goes to [7:0]
rsp_err  output  1  response flagged as faulting (misaligned, or out of range when enabled)
ld_en  input  1  program-load write strobe
ld_addr  input  ADDR_W  load byte address; must be word-aligned, low 2 bits ignored
ld_data  input  32  load word, big-endian, same byte order as rsp_instr
ld_be  input  4  byte enables; ld_be[3] controls ld_data[31:24]
busy  output  1  one or more requests in flight, or a response is held

Behaviour:
- Storage is a byte array of DEPTH_BYTES entries. Memory contents are not reset.
- Reset is asynchronous, active while rst_n=0. During reset: rsp_valid=0, rsp_err=0, rsp_instr=32'h0, busy=0, all pipeline valid bits cleared. Asserting reset mid-operation drops in-flight fetches without producing a response.
- The pipeline has LAT stages, each holding {valid, addr, err}. The stage-LAT output is registered and drives rsp_*.
- advance = !(rsp_valid && !rsp_ready). When advance=0, every stage holds its contents and rsp_* is held stable.
- req_ready = advance && !ld_en. A load therefore stalls request acceptance for the cycle it occurs in.
- An accepted request at cycle t produces rsp_valid at cycle t+LAT, assuming no stalls. With continuous rsp_ready, back-to-back requests sustain a throughput of 1 per cycle.
- Memory is read at the final stage. Data is assembled from bytes a, a+1, a+2, a+3, where a = req_addr mod DEPTH_BYTES.
- Misaligned address (req_addr[1:0] != 0): rsp_err=1 and rsp_instr=32'h0 (NOP). No memory read is used.
- Out-of-range address, macro off: the address wraps modulo DEPTH_BYTES, and a word spanning the top of memory never occurs because the address is aligned.
- Load write: on a clk edge with ld_en=1, each byte whose ld_be bit is set is written at ld_addr with low bits cleared. Out-of-range load addresses wrap modulo DEPTH_BYTES.
- Load and final-stage read to the same word in the same cycle: the read returns the old data (read-before-write). Later reads see the new data.
- Bubbles: when req_valid=0 or req_ready=0, an invalid entry enters stage 1. rsp_valid deasserts when an invalid entry reaches the output.
- busy = OR of all stage valid bits, including the output register.
- LAT=1 degenerates to a single registered read, equivalent to the legacy fetch timing plus the handshake.

Optional Feature:
IMEM_OOR_ERR_EN
- Defined: any req_addr >= DEPTH_BYTES gives rsp_err=1 and rsp_instr=32'h0. Any ld_addr >= DEPTH_BYTES ignores the write entirely.
- Undefined: no range check; fetch and load addresses wrap as described above, and rsp_err reflects misalignment only.

Test Plan:
- Load 32'h2149_0064 at ld_addr 0 with ld_be=4'hF, then fetch 0 with LAT=1 -> one cycle after acceptance, rsp_valid=1, rsp_instr=32'h2149_0064, rsp_err=0.
- LAT=3: fetch 0, 4, 8 on consecutive cycles, with words 0x014B4822, 0x014B6820, 0x100A0006 preloaded -> responses arrive in order on cycles t+3, t+4, t+5 with no bubbles.
- Hold rsp_ready=0 for 4 cycles with 2 requests in flight -> rsp_* stays stable and req_ready=0. Releasing it delivers both responses in order with no loss or duplication.
- Fetch address 0x6 -> rsp_err=1, rsp_instr=0. Fetch 0x104 with DEPTH_BYTES=256: macro on gives rsp_err=1; macro off returns the word at 0x004.
- Write 0xAABBCCDD with ld_be=4'b0101 over an existing 0x11223344 -> a later fetch returns 0x11BB33DD. A same-cycle load and final-stage read of that word returns the old value.
- Assert rst_n=0 with 2 fetches in flight -> rsp_valid=0, busy=0 immediately. After release, memory contents are retained and a new fetch returns the prior word.

Source files
------------

// File: rtl/imem_pipe.sv
// ---------------------------------------------------------------------------
// imem_pipe
//
// Byte-addressed, big-endian instruction memory for the MIPS fetch stage.
// It has a valid/ready fetch interface, a read latency of LAT cycles, an
// alignment check, and a word-wide program-load port. The load port replaces
// initial-block programming.
//
// Parameters:
//   ADDR_W      width of fetch/load byte addresses
//   DEPTH_BYTES memory size in bytes (power of two, multiple of 4)
//   LAT         cycles from accepted request to rsp_valid (1..4)
//
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   req_valid/req_ready     fetch request handshake, req_addr = byte address
//   rsp_valid/rsp_ready     response handshake
//   rsp_instr, rsp_err      fetched word (byte at addr in [31:24]) and fault flag
//   ld_en/ld_addr/ld_data   program-load write (word aligned, low bits ignored)
//   ld_be                   byte enables, ld_be[3] -> ld_data[31:24]
//   busy                    any stage valid, including the output register
//
// Optional feature macro: IMEM_OOR_ERR_EN
//   defined   : fetch address >= DEPTH_BYTES faults; such loads are dropped
//   undefined : fetch and load addresses wrap modulo DEPTH_BYTES
//
// Handshake rule: a transfer happens on a rising edge where valid && ready.
// A held response (rsp_valid && !rsp_ready) freezes the whole pipeline and
// keeps rsp_* stable. A load cycle refuses new requests.
// ---------------------------------------------------------------------------
module imem_pipe #(
    parameter int ADDR_W      = 32,
    parameter int DEPTH_BYTES = 256,
    parameter int LAT         = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [31:0]       rsp_instr,
    output logic              rsp_err,
    input  logic              ld_en,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [31:0]       ld_data,
    input  logic [3:0]        ld_be,
    output logic              busy
);

    localparam int AW = $clog2(DEPTH_BYTES);   // byte index width
    localparam int WW = AW - 2;                // word index width

    // Pipeline stages; index LAT-1 is the output register.
    logic          r_v [LAT];
    logic          r_e [LAT];
    logic [WW-1:0] r_a [LAT];
    logic [31:0]   r_instr;
    logic [7:0]    r_mem [DEPTH_BYTES];

    // Next-state values for each stage (what enters it on an advancing edge).
    logic          w_nv [LAT];
    logic          w_ne [LAT];
    logic [WW-1:0] w_na [LAT];

    logic          w_adv;
    logic          w_acc;
    logic          w_req_err;
    logic          w_ld_we;
    logic [31:0]   w_rd;
    logic          w_busy;
    logic          w_unused;

    assign w_adv     = !(r_v[LAT-1] && !rsp_ready);
    assign req_ready = w_adv && !ld_en;
    assign w_acc     = req_valid && req_ready;

`ifdef IMEM_OOR_ERR_EN
    assign w_req_err = (req_addr[1:0] != 2'b00) || (req_addr >= ADDR_W'(DEPTH_BYTES));
    assign w_ld_we   = ld_en && (ld_addr < ADDR_W'(DEPTH_BYTES));
`else
    assign w_req_err = (req_addr[1:0] != 2'b00);
    assign w_ld_we   = ld_en;
`endif

    // Only the word index travels down the pipe. The error flag already
    // records misalignment, so the low address bits are not needed later.
    always_comb begin
        w_nv[0] = w_acc;
        w_ne[0] = w_acc && w_req_err;
        w_na[0] = req_addr[AW-1:2];
        for (int i = 1; i < LAT; i++) begin
            w_nv[i] = r_v[i-1];
            w_ne[i] = r_e[i-1];
            w_na[i] = r_a[i-1];
        end
    end

    // The memory is read for the entry that enters the output register.
    // Because this is a registered read, a load on the same edge to the
    // same word is not yet visible to it (read-before-write).
    assign w_rd = {r_mem[{w_na[LAT-1], 2'b00}], r_mem[{w_na[LAT-1], 2'b01}],
                   r_mem[{w_na[LAT-1], 2'b10}], r_mem[{w_na[LAT-1], 2'b11}]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < LAT; i++) begin
                r_v[i] <= 1'b0;
                r_e[i] <= 1'b0;
                r_a[i] <= '0;
            end
            r_instr <= 32'h0;
        end else if (w_adv) begin
            for (int i = 0; i < LAT; i++) begin
                r_v[i] <= w_nv[i];
                r_e[i] <= w_ne[i];
                r_a[i] <= w_na[i];
            end
            // Faulting entries and bubbles carry a NOP word.
            r_instr <= (w_nv[LAT-1] && !w_ne[LAT-1]) ? w_rd : 32'h0;
        end
    end

    // Program storage is not reset, so its contents survive rst_n.
    always_ff @(posedge clk) begin
        if (w_ld_we) begin
            for (int b = 0; b < 4; b++) begin
                if (ld_be[3-b]) begin
                    r_mem[{ld_addr[AW-1:2], 2'(b)}] <= ld_data[31-8*b -: 8];
                end
            end
        end
    end

    always_comb begin
        w_busy = 1'b0;
        for (int i = 0; i < LAT; i++) begin
            w_busy = w_busy | r_v[i];
        end
    end

    assign rsp_valid = r_v[LAT-1];
    assign rsp_err   = r_e[LAT-1];
    assign rsp_instr = r_instr;
    assign busy      = w_busy;

    // The output stage address and the upper/lower address bits are
    // intentionally unused.
    assign w_unused = ^{req_addr, ld_addr, r_a[LAT-1]};

endmodule

// File: tb/tb_imem_pipe.sv
// ---------------------------------------------------------------------------
// tb_imem_pipe
//
// Directed bench for imem_pipe. It uses two instances:
//   u_dut1 : LAT=1
//   u_dut3 : LAT=3
// Both instances share the load port, the fetch address, rsp_ready and
// reset. Each instance has its own req_valid.
//
// Inputs change 1 ns after a rising edge. Outputs are sampled at that
// same point, so they are always read away from the active edge.
// ---------------------------------------------------------------------------
module tb_imem_pipe;

    logic        clk;
    logic        rst_n;
    logic        req_valid1;
    logic        req_valid3;
    logic [31:0] req_addr;
    logic        rsp_ready;
    logic        ld_en;
    logic [31:0] ld_addr;
    logic [31:0] ld_data;
    logic [3:0]  ld_be;

    logic        req_ready1;
    logic        req_ready3;
    logic        rsp_valid1;
    logic        rsp_valid3;
    logic [31:0] rsp_instr1;
    logic [31:0] rsp_instr3;
    logic        rsp_err1;
    logic        rsp_err3;
    logic        busy1;
    logic        busy3;

    int n_cmp = 0;
    int n_bad = 0;

    logic [31:0] words [3];

    imem_pipe #(.ADDR_W(32), .DEPTH_BYTES(256), .LAT(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid1), .req_ready(req_ready1), .req_addr(req_addr),
        .rsp_valid(rsp_valid1), .rsp_ready(rsp_ready), .rsp_instr(rsp_instr1),
        .rsp_err(rsp_err1),
        .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data), .ld_be(ld_be),
        .busy(busy1)
    );

    imem_pipe #(.ADDR_W(32), .DEPTH_BYTES(256), .LAT(3)) u_dut3 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid3), .req_ready(req_ready3), .req_addr(req_addr),
        .rsp_valid(rsp_valid3), .rsp_ready(rsp_ready), .rsp_instr(rsp_instr3),
        .rsp_err(rsp_err3),
        .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data), .ld_be(ld_be),
        .busy(busy3)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---- driver tasks ------------------------------------------------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
        ld_en   = 1'b1;
        ld_addr = a;
        ld_data = d;
        ld_be   = be;
        tick();
        ld_en   = 1'b0;
    endtask

    // ---- checker -----------------------------------------------------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, want %h", tag, obs, exp);
        end
    endtask

    initial begin
        rst_n      = 1'b0;
        req_valid1 = 1'b0;
        req_valid3 = 1'b0;
        req_addr   = 32'h0;
        rsp_ready  = 1'b1;
        ld_en      = 1'b0;
        ld_addr    = 32'h0;
        ld_data    = 32'h0;
        ld_be      = 4'h0;

        // ---- reset state ----
        #12;
        check("rst_rsp_valid1", {31'b0, rsp_valid1}, 32'd0);
        check("rst_rsp_instr1", rsp_instr1, 32'h0);
        check("rst_rsp_err1", {31'b0, rsp_err1}, 32'd0);
        check("rst_busy1", {31'b0, busy1}, 32'd0);
        check("rst_rsp_valid3", {31'b0, rsp_valid3}, 32'd0);
        check("rst_busy3", {31'b0, busy3}, 32'd0);
        tick();
        rst_n = 1'b1;
        tick();

        // ---- LAT=1 basic fetch ----
        // While a load is being applied, requests must not be accepted.
        ld_en = 1'b1;
        #1;
        check("ld_blocks_ready", {31'b0, req_ready1}, 32'd0);
        ld_en = 1'b0;
        load(32'h0, 32'h2149_0064, 4'hF);
        req_valid1 = 1'b1;
        req_addr   = 32'h0;
        #1;
        check("lat1_req_ready", {31'b0, req_ready1}, 32'd1);
        tick();
        req_valid1 = 1'b0;
        check("lat1_rsp_valid", {31'b0, rsp_valid1}, 32'd1);
        check("lat1_rsp_instr", rsp_instr1, 32'h2149_0064);
        check("lat1_rsp_err", {31'b0, rsp_err1}, 32'd0);
        tick();
        check("lat1_bubble", {31'b0, rsp_valid1}, 32'd0);
        check("lat1_idle_busy", {31'b0, busy1}, 32'd0);

        // ---- LAT=3: back-to-back fetches ----
        words[0] = 32'h014B_4822;
        words[1] = 32'h014B_6820;
        words[2] = 32'h100A_0006;
        for (int i = 0; i < 3; i++) load(32'(4 * i), words[i], 4'hF);
        for (int k = 1; k <= 6; k++) begin
            req_valid3 = (k <= 3);
            req_addr   = 32'(4 * (k - 1));
            tick();
            if (k >= 3 && k <= 5) begin
                check($sformatf("lat3_valid_k%0d", k), {31'b0, rsp_valid3}, 32'd1);
                check($sformatf("lat3_instr_k%0d", k), rsp_instr3, words[k-3]);
            end else begin
                check($sformatf("lat3_novalid_k%0d", k), {31'b0, rsp_valid3}, 32'd0);
            end
        end
        req_valid3 = 1'b0;

        // ---- LAT=3: backpressure with 2 requests in flight ----
        rsp_ready  = 1'b0;
        req_valid3 = 1'b1;
        req_addr   = 32'h0;
        tick();
        req_addr   = 32'h4;
        tick();
        req_valid3 = 1'b0;
        tick();
        check("bp_first_valid", {31'b0, rsp_valid3}, 32'd1);
        for (int k = 0; k < 4; k++) begin
            tick();
            check($sformatf("bp_hold_valid%0d", k), {31'b0, rsp_valid3}, 32'd1);
            check($sformatf("bp_hold_instr%0d", k), rsp_instr3, words[0]);
            check($sformatf("bp_hold_ready%0d", k), {31'b0, req_ready3}, 32'd0);
            check($sformatf("bp_hold_busy%0d", k), {31'b0, busy3}, 32'd1);
        end
        rsp_ready = 1'b1;
        tick();
        check("bp_second_valid", {31'b0, rsp_valid3}, 32'd1);
        check("bp_second_instr", rsp_instr3, words[1]);
        tick();
        check("bp_drained", {31'b0, rsp_valid3}, 32'd0);
        check("bp_drained_busy", {31'b0, busy3}, 32'd0);

        // ---- misaligned and out-of-range fetches (LAT=1) ----
        req_valid1 = 1'b1;
        req_addr   = 32'h6;
        tick();
        check("mis_err", {31'b0, rsp_err1}, 32'd1);
        check("mis_instr", rsp_instr1, 32'h0);
        req_addr = 32'h104;
        tick();
        req_valid1 = 1'b0;
        check("oor_valid", {31'b0, rsp_valid1}, 32'd1);
`ifdef IMEM_OOR_ERR_EN
        check("oor_err", {31'b0, rsp_err1}, 32'd1);
        check("oor_instr", rsp_instr1, 32'h0);
`else
        check("oor_err", {31'b0, rsp_err1}, 32'd0);
        check("oor_instr", rsp_instr1, words[1]);
`endif
        tick();

        // ---- byte-enable merge ----
        load(32'h10, 32'h1122_3344, 4'hF);
        load(32'h13, 32'hAABB_CCDD, 4'b0101);  // low address bits are ignored
        req_valid1 = 1'b1;
        req_addr   = 32'h10;
        tick();
        req_valid1 = 1'b0;
        check("be_merge", rsp_instr1, 32'h11BB_33DD);
        tick();

        // ---- same-cycle load and final-stage read (LAT=3) ----
        req_valid3 = 1'b1;
        req_addr   = 32'h10;
        tick();
        req_valid3 = 1'b0;
        tick();
        load(32'h10, 32'h5566_7788, 4'hF);   // same edge as final-stage read
        check("rbw_old_valid", {31'b0, rsp_valid3}, 32'd1);
        check("rbw_old_instr", rsp_instr3, 32'h11BB_33DD);
        tick();
        req_valid1 = 1'b1;
        req_addr   = 32'h10;
        tick();
        req_valid1 = 1'b0;
        check("rbw_new_instr", rsp_instr1, 32'h5566_7788);
        tick();

        // ---- reset with fetches in flight (LAT=3) ----
        req_valid3 = 1'b1;
        req_addr   = 32'h0;
        tick();
        req_addr   = 32'h4;
        tick();
        req_valid3 = 1'b0;
        check("pre_rst_busy", {31'b0, busy3}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid", {31'b0, rsp_valid3}, 32'd0);
        check("mid_rst_busy", {31'b0, busy3}, 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        tick();
        check("post_rst_no_rsp", {31'b0, rsp_valid3}, 32'd0);
        req_valid3 = 1'b1;
        req_addr   = 32'h0;
        tick();
        req_valid3 = 1'b0;
        tick();
        tick();
        check("post_rst_valid", {31'b0, rsp_valid3}, 32'd1);
        check("post_rst_instr", rsp_instr3, words[0]);
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    // Absolute time bound so the run always terminates.
    initial begin
        #100000;
        $display("FAIL timeout: got no completion, want completion within 100000 ns");
        $fatal(1);
    end

endmodule
